morse_letter_assembler: RTL and testbench

Sequencer that sits downstream of the dit counter. It turns the counter's 3-bit element/gap classification stream into complete Morse letters and hands them to the character decoder. Received elements are collected into a pattern register. Each letter is closed on a letter or word gap and presented through a single-entry valid/ready output buffer, along with a word-space flag. Over-long letters are discarded and flagged.

---
 rtl/morse_pkg.sv | 24 ++
 rtl/morse_letter_assembler_if.sv | 31 +++
 rtl/morse_event_detect.sv | 40 ++++
 rtl/morse_letter_assembler.sv | 142 ++++++++++++++
 tb/tb_morse_letter_assembler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive chain: classification codes
// produced by the dit counter and the letter-build state encoding.
package morse_pkg;

  // Element/gap classification codes. Codes 5..7 carry no meaning.
  localparam logic [2:0] MC_NONE = 3'd0;
  localparam logic [2:0] MC_DIT  = 3'd1;
  localparam logic [2:0] MC_DAH  = 3'd2;
  localparam logic [2:0] MC_LGAP = 3'd3;
  localparam logic [2:0] MC_WGAP = 3'd4;

  // IDLE: nothing collected and no error pending.
  // BUILD: at least one element collected, or the letter has overflowed.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BUILD = 1'b1
  } bld_state_t;

  // True for the codes that close a letter.
  function automatic logic is_gap(input logic [2:0] code);
    return (code == MC_LGAP) || (code == MC_WGAP);
  endfunction

endpackage

// File: rtl/morse_letter_assembler_if.sv
// Symbol output channel from the letter assembler to the character decoder.
//
// Handshake: the master raises sym_valid when a symbol is held and keeps
// sym_pattern/sym_len/sym_space stable until a rising edge where both
// sym_valid and sym_ready are high; that edge is the transfer. sym_valid never
// depends combinationally on sym_ready.
interface morse_letter_assembler_if #(
  parameter int MAXLEN = 6
) ();
  logic [MAXLEN-1:0] sym_pattern;
  logic [2:0]        sym_len;
  logic              sym_space;
  logic              sym_valid;
  logic              sym_ready;

  modport master (
    output sym_pattern,
    output sym_len,
    output sym_space,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_pattern,
    input  sym_len,
    input  sym_space,
    input  sym_valid,
    output sym_ready
  );
endinterface

// File: rtl/morse_event_detect.sv
// Input register pair and edge-style event decode for the classification
// stream. A code held for many cycles produces a single event; repeating a
// code needs a different code in between.
module morse_event_detect
  import morse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ditsdahs,
  output logic       ev_elem,
  output logic       ev_dah,
  output logic       ev_lgap,
  output logic       ev_wgap
);

  logic [2:0] code_q;
  logic [2:0] prev_q;
  logic       changed;

  // Register the incoming code and keep the previous one for change detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= MC_NONE;
      prev_q <= MC_NONE;
    end else begin
      code_q <= ditsdahs;
      prev_q <= code_q;
    end
  end

  // Decode an event whenever a meaningful code appears for the first cycle.
  always_comb begin
    changed = (code_q != prev_q);
    ev_elem = changed && ((code_q == MC_DIT) || (code_q == MC_DAH));
    ev_dah  = changed && (code_q == MC_DAH);
    ev_lgap = changed && (code_q == MC_LGAP);
    ev_wgap = changed && (code_q == MC_WGAP);
  end

endmodule

// File: rtl/morse_letter_assembler.sv
// Collects dits/dahs into a pattern, closes the letter on a gap and presents
// it through a single-entry valid/ready buffer together with a word-space
// flag. Letters longer than MAXLEN (legal 1..7) are discarded and flagged.
module morse_letter_assembler
  import morse_pkg::*;
#(
  parameter int MAXLEN = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               ditsdahs,
  morse_letter_assembler_if.master sym,
  output logic                     overflow,
  output logic                     lost,
  output bld_state_t               state
);

  localparam logic [2:0] LEN_MAX = 3'(MAXLEN);

  logic ev_elem, ev_dah, ev_lgap, ev_wgap;

  morse_event_detect u_event_detect (
    .clk      (clk),
    .reset    (reset),
    .ditsdahs (ditsdahs),
    .ev_elem  (ev_elem),
    .ev_dah   (ev_dah),
    .ev_lgap  (ev_lgap),
    .ev_wgap  (ev_wgap)
  );

  // Build state
  bld_state_t        state_q, state_d;
  logic [MAXLEN-1:0] bld_pat, pat_d;
  logic [2:0]        bld_len, len_d;
  logic              bld_err, err_d;

  // Output buffer and flags
  logic [MAXLEN-1:0] buf_pat;
  logic [2:0]        buf_len;
  logic              buf_space;
  logic              buf_valid;
  logic              last_space;

  // Symbol produced this cycle
  logic              emit;
  logic [MAXLEN-1:0] emit_pat;
  logic [2:0]        emit_len;
  logic              emit_space;
  logic              ovf_d;
  logic              load;
  logic              drop;

  assign state = state_q;

  // Next build state and the symbol (if any) closed by this cycle's event.
  always_comb begin
    state_d    = state_q;
    pat_d      = bld_pat;
    len_d      = bld_len;
    err_d      = bld_err;
    emit       = 1'b0;
    emit_pat   = '0;
    emit_len   = 3'd0;
    emit_space = 1'b0;
    ovf_d      = 1'b0;

    if (ev_elem) begin
      if (bld_len < LEN_MAX) begin
        pat_d    = bld_pat << 1;
        pat_d[0] = ev_dah;
        len_d    = bld_len + 3'd1;
      end else begin
        err_d = 1'b1;
      end
      state_d = ST_BUILD;
    end else if (ev_lgap || ev_wgap) begin
      if (state_q == ST_BUILD) begin
        if (bld_err) begin
          // Over-long letter: report it and drop it, word space included.
          ovf_d = 1'b1;
        end else begin
          emit       = 1'b1;
          emit_pat   = bld_pat;
          emit_len   = bld_len;
          emit_space = ev_wgap;
        end
      end else if (ev_wgap && !last_space) begin
        // Bare word space; suppressed at start and after another space.
        emit       = 1'b1;
        emit_space = 1'b1;
      end
      state_d = ST_IDLE;
      pat_d   = '0;
      len_d   = 3'd0;
      err_d   = 1'b0;
    end

    // The buffer accepts when empty or when it drains on the same edge.
    load = emit && (!buf_valid || sym.sym_ready);
    drop = emit && !load;
  end

  // Build registers, output buffer and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bld_pat    <= '0;
      bld_len    <= 3'd0;
      bld_err    <= 1'b0;
      buf_pat    <= '0;
      buf_len    <= 3'd0;
      buf_space  <= 1'b0;
      buf_valid  <= 1'b0;
      last_space <= 1'b1;
      overflow   <= 1'b0;
      lost       <= 1'b0;
    end else begin
      state_q  <= state_d;
      bld_pat  <= pat_d;
      bld_len  <= len_d;
      bld_err  <= err_d;
      overflow <= ovf_d;
      lost     <= drop;
      if (load) begin
        buf_pat    <= emit_pat;
        buf_len    <= emit_len;
        buf_space  <= emit_space;
        buf_valid  <= 1'b1;
        last_space <= emit_space;
      end else if (buf_valid && sym.sym_ready) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign sym.sym_pattern = buf_pat;
  assign sym.sym_len     = buf_len;
  assign sym.sym_space   = buf_space;
  assign sym.sym_valid   = buf_valid;

endmodule

// File: tb/tb_morse_letter_assembler.sv
// Bench for morse_letter_assembler (MAXLEN = 6): table of letter sequences
// with expected symbols, plus hand sequences for latency, overflow,
// backpressure and asynchronous reset.
module tb_morse_letter_assembler;
  import morse_pkg::*;

  localparam int ML = 6;

  logic       clk;
  logic       reset;
  logic [2:0] ditsdahs;
  logic       overflow;
  logic       lost;
  bld_state_t state_dbg;

  morse_letter_assembler_if #(.MAXLEN(ML)) sym_if ();

  morse_letter_assembler #(.MAXLEN(ML)) dut (
    .clk      (clk),
    .reset    (reset),
    .ditsdahs (ditsdahs),
    .sym      (sym_if.master),
    .overflow (overflow),
    .lost     (lost),
    .state    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed symbol: {space, len[2:0], pattern[5:0]}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int lost_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic sp, input logic [2:0] len, input logic [5:0] pat);
    return {sp, len, pat};
  endfunction

  // Compare every transferred symbol with the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && sym_if.sym_valid && sym_if.sym_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_symbol", {22'd0, sym_if.sym_space, sym_if.sym_len, sym_if.sym_pattern}, 32'h3ff);
      end else begin
        chk("symbol", {22'd0, sym_if.sym_space, sym_if.sym_len, sym_if.sym_pattern},
            {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Count status pulses (one count per high cycle).
  always @(negedge clk) begin
    if (!reset && overflow) ovf_cnt++;
    if (!reset && lost) lost_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [2:0] c);
    ditsdahs = c;
    @(posedge clk);
    #1;
  endtask

  task automatic put_seq(input string s);
    for (int i = 0; i < s.len(); i++) put(3'(s[i] - 8'd48));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      seq;
    bit         emits;
    logic [2:0] len;
    logic [5:0] pat;
    bit         space;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"10203",         1'b1, 3'd2, 6'b000001, 1'b0}; // A
    vecs[1] = '{"20104",         1'b1, 3'd2, 6'b000010, 1'b1}; // N + word gap
    vecs[2] = '{"04",            1'b0, 3'd0, 6'b000000, 1'b0}; // repeated space
    vecs[3] = '{"103",           1'b1, 3'd1, 6'b000000, 1'b0}; // E
    vecs[4] = '{"04",            1'b1, 3'd0, 6'b000000, 1'b1}; // bare space
    vecs[5] = '{"04",            1'b0, 3'd0, 6'b000000, 1'b0}; // suppressed
    vecs[6] = '{"1050703",       1'b1, 3'd1, 6'b000000, 1'b0}; // 5/7 ignored
    vecs[7] = '{"2020202020203", 1'b1, 3'd6, 6'b111111, 1'b0}; // exactly MAXLEN
    vecs[8] = '{"30",            1'b0, 3'd0, 6'b000000, 1'b0}; // gap in IDLE
    vecs[9] = '{"2120104",       1'b1, 3'd4, 6'b001010, 1'b1}; // C + word gap
  end

  // ---------------- test sequence ----------------
  initial begin
    reset     = 1'b1;
    ditsdahs  = MC_NONE;
    sym_if.sym_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",    sym_if.sym_valid,   0);
    chk("rst_pattern",  sym_if.sym_pattern, 0);
    chk("rst_len",      sym_if.sym_len,     0);
    chk("rst_space",    sym_if.sym_space,   0);
    chk("rst_overflow", overflow,           0);
    chk("rst_lost",     lost,               0);
    chk("rst_state",    state_dbg,          ST_IDLE);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Letter A with latency and single-cycle valid.
    exp_q.push_back(mk(1'b0, 3'd2, 6'b000001));
    put_seq("1020");
    ditsdahs = MC_LGAP;
    @(posedge clk);                       // edge k: gap code sampled
    @(negedge clk);
    chk("a_valid_k", sym_if.sym_valid, 0);
    ditsdahs = MC_NONE;
    @(posedge clk);                       // edge k+1: symbol loaded
    @(negedge clk);
    chk("a_valid_k1", sym_if.sym_valid, 1);
    @(posedge clk);
    @(negedge clk);
    chk("a_valid_k2", sym_if.sym_valid, 0);
    @(posedge clk);
    #1;
    drain("a_drain");

    // Table-driven letters with sym_ready held high.
    foreach (vecs[i]) begin
      if (vecs[i].emits) exp_q.push_back(mk(vecs[i].space, vecs[i].len, vecs[i].pat));
      put_seq(vecs[i].seq);
      put(MC_NONE);
      put(MC_NONE);
      drain("table_drain");
    end
    chk("table_overflow", ovf_cnt, 0);
    chk("table_lost", lost_cnt, 0);

    // Held code: one dit however long it is held.
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000000));
    repeat (20) put(MC_DIT);
    put_seq("300");
    drain("held_drain");

    // Overflow: seven dits then a letter gap.
    for (int i = 0; i < 7; i++) put_seq("10");
    put_seq("3000");
    chk("ovf_count", ovf_cnt, 1);
    chk("ovf_state", state_dbg, ST_IDLE);
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000001));
    put_seq("20300");
    drain("ovf_next_drain");
    chk("ovf_count_after", ovf_cnt, 1);

    // Backpressure: E held, T lost, then E transferred alone.
    sym_if.sym_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000000));
    put_seq("10300");
    put_seq("20300");
    @(negedge clk);
    chk("bp_valid", sym_if.sym_valid, 1);
    chk("bp_len",   sym_if.sym_len, 1);
    chk("bp_pat",   sym_if.sym_pattern, 0);
    chk("bp_lost",  lost_cnt, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_len", sym_if.sym_len, 1);
    @(posedge clk);
    #1;
    sym_if.sym_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", sym_if.sym_valid, 0);
    chk("bp_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Same-edge drain and load.
    sym_if.sym_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000000));
    put_seq("10300");
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000001));
    put_seq("20");
    ditsdahs = MC_LGAP;
    @(posedge clk);                       // edge k
    #1;
    sym_if.sym_ready = 1'b1;
    ditsdahs = MC_NONE;
    @(posedge clk);                       // edge k+1: drain E, load T
    @(negedge clk);
    chk("same_valid", sym_if.sym_valid, 1);
    chk("same_pat",   sym_if.sym_pattern, 1);
    @(posedge clk);
    #1;
    drain("same_drain");
    chk("same_lost", lost_cnt, 1);

    // Asynchronous reset in the middle of a letter.
    put_seq("202");
    ditsdahs = MC_NONE;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid",  sym_if.sym_valid, 0);
    chk("arst_len",    sym_if.sym_len, 0);
    chk("arst_pat",    sym_if.sym_pattern, 0);
    chk("arst_space",  sym_if.sym_space, 0);
    chk("arst_state",  state_dbg, ST_IDLE);
    chk("arst_ovf",    overflow, 0);
    chk("arst_lost",   lost, 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    put_seq("0400");                      // leading word gap: nothing
    exp_q.push_back(mk(1'b0, 3'd1, 6'b000000));
    put_seq("10300");
    drain("arst_drain");
    chk("final_ovf",  ovf_cnt, 1);
    chk("final_lost", lost_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
